// File: rtl/decoder_seq_pkg.sv
// decoder_seq_pkg: shared types and encodings for the decoder_seq block.
// Holds the FSM state enum and the encodings of the mode input.

package decoder_seq_pkg;

  // Controller states. IDLE is the reset state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  // Encodings of the mode input.
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : decoder_seq_pkg

// File: rtl/decoder_onehot.sv
// decoder_onehot: purely combinational IN_W -> 2**IN_W one-hot decoder.
// Exactly one output bit is set for every select value.

module decoder_onehot #(
  parameter int IN_W = 2
) (
  input  logic [IN_W-1:0]      sel_i,
  output logic [(1<<IN_W)-1:0] onehot_o
);

  // Set only the bit addressed by the select.
  always_comb begin
    onehot_o        = '0;
    onehot_o[sel_i] = 1'b1;
  end

endmodule : decoder_onehot

// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot decoder with an optional scan walker.
//   DIRECT: in_sel is decoded on each accepted transfer (latency 1).
//   SCAN:   a single hot bit walks 0..OUT_W-1, each position held DWELL cycles,
//           with a one-cycle scan_wrap pulse when the index returns to 0.
// Optional feature: define DECODER_SEQ_SCAN_EN to build the SCAN state and its
// registers. Without it, mode is ignored (treated as DIRECT) and scan_idx /
// scan_wrap are tied to 0.

module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int IN_W  = 2,   // select width, 1..6
  parameter int DWELL = 1    // cycles each scan position is held, >= 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  mode_i,
  input  logic                  in_valid_i,
  input  logic [IN_W-1:0]       in_sel_i,
  output logic                  in_ready_o,
  output logic [(1<<IN_W)-1:0]  out_onehot_o,
  output logic                  out_valid_o,
  output logic [IN_W-1:0]       scan_idx_o,
  output logic                  scan_wrap_o
);

  localparam int OUT_W = 1 << IN_W;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic             mode_scan;
  logic             accept;
  logic [IN_W-1:0]  dec_sel;
  logic [OUT_W-1:0] dec_onehot;

`ifdef DECODER_SEQ_SCAN_EN
  localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  logic [IN_W-1:0] scan_idx_q, scan_idx_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic            wrap_q, wrap_d;

  assign mode_scan = (mode_i == MODE_SCAN);
`else
  // Without the scan feature the mode input has no effect.
  logic unused_mode;
  assign unused_mode = mode_i;
  assign mode_scan   = 1'b0;
`endif

  assign in_ready_o = (state_q == DIRECT);
  assign accept     = in_valid_i & in_ready_o;

  // Next state: en low always returns to IDLE; otherwise mode picks the state.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    if (!en_i) begin
      state_d = IDLE;
    end else if (mode_scan) begin
      state_d = SCAN;
    end else begin
      state_d = DIRECT;
    end
  end

`ifdef DECODER_SEQ_SCAN_EN
  // Scan walker: restart on entry, step every DWELL cycles, flag the wrap.
  always_comb begin
    scan_idx_d = scan_idx_q;
    dwell_d    = dwell_q;
    wrap_d     = 1'b0;
    case (state_d)
      IDLE: begin
        scan_idx_d = '0;
        dwell_d    = '0;
      end
      DIRECT: begin
        // Leaving or staying out of SCAN keeps scan_idx where it stopped.
        dwell_d = '0;
      end
      SCAN: begin
        if (state_q != SCAN) begin
          scan_idx_d = '0;
          dwell_d    = '0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d    = '0;
          scan_idx_d = scan_idx_q + 1'b1;
          wrap_d     = &scan_idx_q;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: begin
        scan_idx_d = '0;
        dwell_d    = '0;
      end
    endcase
  end

  // The shared decoder sees the next scan position while scanning.
  assign dec_sel = (state_d == SCAN) ? scan_idx_d : in_sel_i;
`else
  assign dec_sel = in_sel_i;
`endif

  decoder_onehot #(
    .IN_W (IN_W)
  ) u_decoder_onehot (
    .sel_i    (dec_sel),
    .onehot_o (dec_onehot)
  );

  // Output data: load on accept, hold otherwise, clear on any state entry
  // other than SCAN; SCAN always shows the decoded scan position.
  always_comb begin
    onehot_d = onehot_q;
    valid_d  = valid_q;
    case (state_d)
      DIRECT: begin
        if (state_q != DIRECT) begin
          onehot_d = '0;
          valid_d  = 1'b0;
        end else if (accept) begin
          onehot_d = dec_onehot;
          valid_d  = 1'b1;
        end
      end
`ifdef DECODER_SEQ_SCAN_EN
      SCAN: begin
        onehot_d = dec_onehot;
        valid_d  = 1'b1;
      end
`endif
      default: begin
        onehot_d = '0;
        valid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
    end
  end

`ifdef DECODER_SEQ_SCAN_EN
  // Scan index, dwell counter and wrap pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx_q <= '0;
      dwell_q    <= '0;
      wrap_q     <= 1'b0;
    end else begin
      scan_idx_q <= scan_idx_d;
      dwell_q    <= dwell_d;
      wrap_q     <= wrap_d;
    end
  end

  assign scan_idx_o  = scan_idx_q;
  assign scan_wrap_o = wrap_q;
`else
  assign scan_idx_o  = '0;
  assign scan_wrap_o = 1'b0;
`endif

  assign out_onehot_o = onehot_q;
  assign out_valid_o  = valid_q;

endmodule : decoder_seq

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed self-checking bench for decoder_seq.
// Two instances share the control inputs: dut_a (IN_W=2, DWELL=1) and
// dut_b (IN_W=3, DWELL=2). Scan checks are built when DECODER_SEQ_SCAN_EN is
// defined; otherwise the mode-ignored behaviour is checked.

module tb_decoder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic       in_valid;
  logic [1:0] sel_a;
  logic [2:0] sel_b;

  logic       a_ready, a_valid, a_wrap;
  logic [3:0] a_onehot;
  logic [1:0] a_idx;
  logic       b_ready, b_valid, b_wrap;
  logic [7:0] b_onehot;
  logic [2:0] b_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_seq #(.IN_W(2), .DWELL(1)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .mode_i       (mode),
    .in_valid_i   (in_valid),
    .in_sel_i     (sel_a),
    .in_ready_o   (a_ready),
    .out_onehot_o (a_onehot),
    .out_valid_o  (a_valid),
    .scan_idx_o   (a_idx),
    .scan_wrap_o  (a_wrap)
  );

  decoder_seq #(.IN_W(3), .DWELL(2)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .mode_i       (mode),
    .in_valid_i   (in_valid),
    .in_sel_i     (sel_b),
    .in_ready_o   (b_ready),
    .out_onehot_o (b_onehot),
    .out_valid_o  (b_valid),
    .scan_idx_o   (b_idx),
    .scan_wrap_o  (b_wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; sel_a = '0; sel_b = '0;
    #12;
    check("rst_ready",  32'(a_ready),  32'h0);
    check("rst_onehot", 32'(a_onehot), 32'h0);
    check("rst_valid",  32'(a_valid),  32'h0);
    check("rst_idx_b",  32'(b_idx),    32'h0);
    check("rst_wrap_b", 32'(b_wrap),   32'h0);
    rst = 1'b0;

    tick();
    check("idle_ready", 32'(a_ready), 32'h0);

    // Enter DIRECT, decode 0..3 back to back.
    en = 1'b1; mode = 1'b0;
    tick();
    check("direct_ready_a", 32'(a_ready), 32'h1);
    check("direct_ready_b", 32'(b_ready), 32'h1);
    check("direct_valid0",  32'(a_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; sel_a = 2'(i); sel_b = 3'(i);
      tick();
      check("dec_a",   32'(a_onehot), 32'h1 << i);
      check("dec_va",  32'(a_valid),  32'h1);
      check("dec_b",   32'(b_onehot), 32'h1 << i);
    end
    sel_a = 2'd1; sel_b = 3'd7;
    tick();
    check("dec_b_top", 32'(b_onehot), 32'h80);
    check("dec_a_1",   32'(a_onehot), 32'h2);

    // No accept: outputs hold.
    in_valid = 1'b0; sel_a = '0; sel_b = '0;
    tick();
    check("hold_a", 32'(a_onehot), 32'h2);
    check("hold_b", 32'(b_onehot), 32'h80);
    check("hold_v", 32'(a_valid),  32'h1);

    // Accept with en dropping on the same edge: en wins.
    in_valid = 1'b1; sel_a = 2'd3; sel_b = 3'd3; en = 1'b0;
    tick();
    check("enfall_valid",  32'(a_valid),  32'h0);
    check("enfall_onehot", 32'(a_onehot), 32'h0);
    check("enfall_ready",  32'(a_ready),  32'h0);
    check("enfall_valid_b",32'(b_valid),  32'h0);

    // in_valid ignored in IDLE, and on the IDLE->DIRECT entry edge.
    tick();
    check("idle_ignore", 32'(a_valid), 32'h0);
    en = 1'b1;
    tick();
    check("entry_nodec", 32'(a_valid), 32'h0);
    check("entry_ready", 32'(a_ready), 32'h1);
    tick();
    check("entry_dec", 32'(a_onehot), 32'h8);

`ifdef DECODER_SEQ_SCAN_EN
    // SCAN with in_valid held high: no decode of in_sel.
    mode = 1'b1;
    tick();
    check("scan_entry_idx",   32'(b_idx),    32'h0);
    check("scan_entry_oh",    32'(b_onehot), 32'h1);
    check("scan_entry_valid", 32'(b_valid),  32'h1);
    check("scan_entry_wrap",  32'(b_wrap),   32'h0);
    check("scan_entry_ready", 32'(a_ready),  32'h0);
    check("scan_entry_idx_a", 32'(a_idx),    32'h0);
    for (int c = 1; c <= 26; c++) begin
      tick();
      check("scan_idx_b",  32'(b_idx),    32'((c / 2) % 8));
      check("scan_oh_b",   32'(b_onehot), 32'h1 << ((c / 2) % 8));
      check("scan_wrap_b", 32'(b_wrap),   32'(c == 16));
      check("scan_idx_a",  32'(a_idx),    32'(c % 4));
      check("scan_wrap_a", 32'(a_wrap),   32'(c % 4 == 0));
    end

    // Asynchronous reset at scan_idx = 5.
    #2 rst = 1'b1;
    #1;
    check("arst_idx_b",  32'(b_idx),    32'h0);
    check("arst_oh_b",   32'(b_onehot), 32'h0);
    check("arst_v_b",    32'(b_valid),  32'h0);
    check("arst_idx_a",  32'(a_idx),    32'h0);
    #2 rst = 1'b0;
    tick();
    check("rescan_idx_b", 32'(b_idx),    32'h0);
    check("rescan_oh_b",  32'(b_onehot), 32'h1);
    check("rescan_v_b",   32'(b_valid),  32'h1);
    tick();
    check("rescan_dwell_b", 32'(b_idx), 32'h0);
    check("rescan_idx_a",   32'(a_idx), 32'h1);
    tick();
    check("rescan_step_b", 32'(b_idx), 32'h1);

    // SCAN -> DIRECT: outputs cleared, scan_idx holds, until next accept.
    mode = 1'b0; in_valid = 1'b0;
    tick();
    check("s2d_valid_b", 32'(b_valid),  32'h0);
    check("s2d_oh_b",    32'(b_onehot), 32'h0);
    check("s2d_idx_b",   32'(b_idx),    32'h1);
    check("s2d_idx_a",   32'(a_idx),    32'h2);
    check("s2d_ready_b", 32'(b_ready),  32'h1);
    tick();
    check("s2d_wait_b", 32'(b_valid), 32'h0);
    in_valid = 1'b1; sel_a = 2'd1; sel_b = 3'd6;
    tick();
    check("s2d_dec_b", 32'(b_onehot), 32'h40);
    check("s2d_dv_b",  32'(b_valid),  32'h1);
    check("s2d_dec_a", 32'(a_onehot), 32'h2);

    // Re-enter SCAN from DIRECT, then drop en.
    in_valid = 1'b0; mode = 1'b1;
    tick();
    check("reentry_idx_b", 32'(b_idx),    32'h0);
    check("reentry_oh_b",  32'(b_onehot), 32'h1);
    check("reentry_idx_a", 32'(a_idx),    32'h0);
    en = 1'b0;
    tick();
    check("scan_off_v",   32'(b_valid),  32'h0);
    check("scan_off_oh",  32'(b_onehot), 32'h0);
    check("scan_off_rdy", 32'(b_ready),  32'h0);
    check("scan_off_wrp", 32'(b_wrap),   32'h0);
`else
    // Mode is ignored: mode=1 still decodes directly.
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; sel_a = 2'(i); sel_b = 3'(i);
      tick();
      check("nomode_oh_a",  32'(a_onehot), 32'h1 << i);
      check("nomode_rdy_a", 32'(a_ready),  32'h1);
      check("nomode_wrp_a", 32'(a_wrap),   32'h0);
      check("nomode_idx_a", 32'(a_idx),    32'h0);
      check("nomode_wrp_b", 32'(b_wrap),   32'h0);
    end
    in_valid = 1'b0;
    tick();
    check("nomode_hold", 32'(a_onehot), 32'h8);

    // IDLE entry with mode=1 still lands in DIRECT.
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    check("nomode_entry_rdy", 32'(a_ready), 32'h1);
    check("nomode_entry_v",   32'(a_valid), 32'h0);

    // Asynchronous reset after an accept.
    in_valid = 1'b1; sel_a = 2'd2;
    tick();
    check("pre_arst_oh", 32'(a_onehot), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("arst_oh", 32'(a_onehot), 32'h0);
    check("arst_v",  32'(a_valid),  32'h0);
    check("arst_rdy",32'(a_ready),  32'h0);
    #2 rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_decoder_seq

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter IN_W, default 2, select width; SHALL be 1..6; OUT_W = 2**IN_W.
REQ-002 Parameter DWELL, default 1, cycles each scan position is held; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  block enable; 0 forces outputs idle.
REQ-006 mode  input  1  0 = DIRECT decode, 1 = SCAN walk.
REQ-007 in_valid  input  1  in_sel valid this cycle.
REQ-008 in_sel  input  IN_W  index to decode.
REQ-009 in_ready  output  1  block accepts in_sel this cycle.
REQ-010 out_onehot  output  OUT_W  registered one-hot decode.
REQ-011 out_valid  output  1  out_onehot holds a decoded value.
REQ-012 scan_idx  output  IN_W  current scan position.
REQ-013 scan_wrap  output  1  one-cycle pulse on scan wrap.

Function
REQ-014 FSM states SHALL be IDLE, DIRECT, SCAN; reset state IDLE.
REQ-015 IDLE -> DIRECT when en=1 and mode=0; IDLE -> SCAN when en=1 and mode=1.
REQ-016 Any state -> IDLE on the cycle after en samples 0; outputs cleared on that same edge.
REQ-017 DIRECT -> SCAN and SCAN -> DIRECT on mode change while en=1, taking effect on the next edge.
REQ-018 in_ready SHALL be 1 only in DIRECT; combinational from state.
REQ-019 Accept = in_valid & in_ready; on accept, out_onehot = 1 << in_sel and out_valid = 1 at the next edge (latency 1).
REQ-020 In DIRECT without an accept, out_onehot and out_valid SHALL hold their values.
REQ-021 In DIRECT, out_onehot SHALL have exactly one bit set whenever out_valid = 1.
REQ-022 On entry to SCAN: scan_idx = 0, dwell counter = 0, out_onehot = 1, out_valid = 1.
REQ-023 In SCAN, the dwell counter SHALL count 0..DWELL-1; at DWELL-1, scan_idx increments modulo OUT_W and the dwell counter returns to 0.
REQ-024 out_onehot SHALL equal 1 << scan_idx throughout SCAN.
REQ-025 scan_wrap SHALL be 1 for exactly the one cycle in which scan_idx has just moved from OUT_W-1 to 0; it is 0 otherwise.
REQ-026 On leaving SCAN for DIRECT: out_onehot = 0, out_valid = 0 until the first accept; scan_idx holds its value.
REQ-027 in_valid SHALL be ignored in IDLE and SCAN; no state change results.
REQ-028 If en falls on the same edge as an accept, en wins: out_valid = 0 and out_onehot = 0.

Reset
REQ-029 Asserting rst SHALL, without a clock edge, force: state IDLE, out_onehot 0, out_valid 0, scan_idx 0, dwell counter 0, scan_wrap 0.
REQ-030 Reset asserted mid-scan or mid-accept SHALL discard all progress; after release the FSM re-enters per REQ-015 and the scan restarts at 0.

Configuration
REQ-031 Macro DECODER_SEQ_SCAN_EN defined: SCAN state, dwell counter, scan_idx and scan_wrap logic SHALL be present per REQ-022..026.
REQ-032 Macro undefined: mode SHALL be ignored and treated as 0; scan_idx and scan_wrap SHALL be tied to 0; no scan registers are instantiated.

Structure
REQ-033 Package decoder_seq_pkg SHALL hold the state enum (IDLE, DIRECT, SCAN) and the mode encodings MODE_DIRECT = 0 and MODE_SCAN = 1.
REQ-034 Sub-module decoder_onehot, a pure combinational IN_W -> OUT_W decoder, SHALL be instantiated once, fed by in_sel or scan_idx according to state.

Verification
REQ-035 IN_W=2, en=1, mode=0; accept in_sel = 0,1,2,3 on consecutive cycles -> out_onehot = 0001, 0010, 0100, 1000, each one cycle after its accept.
REQ-036 IN_W=3, DWELL=2, mode=1 for 18 cycles -> scan_idx steps 0..7 with each value held 2 cycles; scan_wrap pulses once, at return to 0.
REQ-037 Accept in_sel=3 with en dropped on the same cycle -> out_valid = 0 and out_onehot = 0 next cycle; in_ready = 0.
REQ-038 Assert rst asynchronously mid-scan at scan_idx = 5 -> outputs zero immediately; after release with mode=1, the scan restarts at 0.
REQ-039 Switch mode 1 -> 0 mid-scan -> out_valid = 0 until the next accept; in_valid held high in SCAN causes no decode.
REQ-040 Build without DECODER_SEQ_SCAN_EN, mode=1 -> DIRECT behaviour as in REQ-035; scan_wrap stays 0.
